deser_rx: RTL and testbench

- Serial-to-parallel receiver: the far end of a single-bit line driven through the standard-cell buffer chain.
- Samples one bit per CLK cycle and assembles W-bit frames delimited by a frame-start strobe.
- Hands each completed word to a consumer through a VLD/RDY holding register, with sticky overrun detection.
- Sits at the input side of a chip-level serial link, between the pad/buffer tree and the parallel datapath.

---
 rtl/deser_rx_pkg.sv | 25 ++
 rtl/deser_hold_reg.sv | 40 ++++
 rtl/deser_rx.sv | 92 +++++++++
 tb/tb_deser_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_rx_pkg.sv
// Shared definitions for the deser_rx serial receiver: FSM encoding,
// counter sizing and the bit-order helper.
package deser_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..w-1; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// VLD/RDY holding register for completed words, with sticky overrun flag.
module deser_hold_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         RDY,
  input  logic         CLR,
  output logic [W-1:0] O,
  output logic         VLD,
  output logic         OVR
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      O   <= '0;
      VLD <= 1'b0;
      OVR <= 1'b0;
    end else begin
      if (load) begin
        // A full register only takes the new word if the old one leaves now.
        if (!VLD || RDY) begin
          O   <= word;
          VLD <= 1'b1;
        end
      end else if (VLD && RDY) begin
        VLD <= 1'b0;
      end

      // Set has priority over clear so a drop is never lost.
      if (load && VLD && !RDY) OVR <= 1'b1;
      else if (CLR)            OVR <= 1'b0;
    end
  end

endmodule

// File: rtl/deser_rx.sv
// Serial-to-parallel receiver: FS-delimited W-bit frames, one bit per CLK,
// delivered through a VLD/RDY holding register.
module deser_rx
  import deser_rx_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         I,
  input  logic         FS,
  input  logic         RDY,
  input  logic         CLR,
  output logic [W-1:0] O,
  output logic         VLD,
  output logic         OVR,
  output logic         BUSY
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-2:0]   sr_q, sr_d;
  logic [W-1:0]   word_raw, word;
  logic           load;

  // Earliest bit sits at the top of word_raw; the final bit comes straight from I.
  assign word_raw = {sr_q, I};

  generate
    if (MSB_FIRST) begin : g_msb
      assign word = word_raw;
    end else begin : g_lsb
      assign word = W'(bit_rev(32'(word_raw), W));
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    load    = 1'b0;

    if (FS) begin
      // FS starts a frame from either state; a partial frame is simply dropped.
      state_d = SHIFT;
      cnt_d   = CW'(1);
      sr_d    = (W-1)'(I);
    end else if (state_q == SHIFT) begin
      sr_d = (W-1)'({sr_q, I});
      if (cnt_q == LAST) begin
        load    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign BUSY = (state_q == SHIFT);

  deser_hold_reg #(.W(W)) u_hold (
    .CLK  (CLK),
    .RSTN (RSTN),
    .load (load),
    .word (word),
    .RDY  (RDY),
    .CLR  (CLR),
    .O    (O),
    .VLD  (VLD),
    .OVR  (OVR)
  );

endmodule

// File: tb/tb_deser_rx.sv
// Self-checking bench for deser_rx: directed frames plus random traffic on a
// W=8 MSB-first instance, and bit-order checks on a W=4 LSB-first instance.
module tb_deser_rx;

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;

  logic       fs8 = 1'b0, i8 = 1'b0, rdy8 = 1'b0, clr8 = 1'b0;
  logic [7:0] o8;
  logic       vld8, ovr8, busy8;

  logic       fs4 = 1'b0, i4 = 1'b0, rdy4 = 1'b0, clr4 = 1'b0;
  logic [3:0] o4;
  logic       vld4, ovr4, busy4;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  deser_rx #(.W(8), .MSB_FIRST(1'b1)) dut8 (
    .CLK(CLK), .RSTN(RSTN), .I(i8), .FS(fs8), .RDY(rdy8), .CLR(clr8),
    .O(o8), .VLD(vld8), .OVR(ovr8), .BUSY(busy8)
  );

  deser_rx #(.W(4), .MSB_FIRST(1'b0)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .I(i4), .FS(fs4), .RDY(rdy4), .CLR(clr4),
    .O(o4), .VLD(vld4), .OVR(ovr4), .BUSY(busy4)
  );

  // Reference model for the W=8 instance: the frame is a list of received
  // bits, the word is formed arithmetically once eight bits are collected.
  int         frame_q[$];
  bit         m_inframe;
  logic [7:0] m_o;
  bit         m_vld, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_inframe = 1'b0;
    m_o       = 8'h00;
    m_vld     = 1'b0;
    m_ovr     = 1'b0;
  endtask

  task automatic model_edge(input bit fs, input bit i, input bit rdy, input bit clr);
    bit complete;
    int w;
    complete = 1'b0;
    w        = 0;
    if (fs) begin
      frame_q.delete();
      frame_q.push_back(int'(i));
      m_inframe = 1'b1;
    end else if (m_inframe) begin
      frame_q.push_back(int'(i));
      if (frame_q.size() == 8) begin
        complete = 1'b1;
        foreach (frame_q[k]) w = w * 2 + frame_q[k];
        frame_q.delete();
        m_inframe = 1'b0;
      end
    end
    if (complete && m_vld && !rdy)  m_ovr = 1'b1;
    else if (clr)                   m_ovr = 1'b0;
    if (complete) begin
      if (!m_vld || rdy) begin
        m_o   = 8'(w);
        m_vld = 1'b1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check8(input string tag);
    check({tag, ".o"},    32'(o8),    32'(m_o));
    check({tag, ".vld"},  32'(vld8),  32'(m_vld));
    check({tag, ".ovr"},  32'(ovr8),  32'(m_ovr));
    check({tag, ".busy"}, 32'(busy8), 32'(m_inframe));
  endtask

  task automatic edge8(input string tag, input bit fs, input bit i, input bit rdy, input bit clr);
    fs8  = fs;
    i8   = i;
    rdy8 = rdy;
    clr8 = clr;
    @(posedge CLK);
    model_edge(fs, i, rdy, clr);
    #1;
    check8(tag);
  endtask

  task automatic send8(input string tag, input logic [7:0] w, input bit rdy_last, input bit clr_last);
    for (int k = 0; k < 8; k++) begin
      edge8(tag, k == 0, w[3'(7 - k)], (k == 7) ? rdy_last : 1'b0, (k == 7) ? clr_last : 1'b0);
    end
  endtask

  task automatic idle8(input string tag, input int n, input bit rdy);
    for (int k = 0; k < n; k++) edge8(tag, 1'b0, 1'($urandom), rdy, 1'b0);
  endtask

  task automatic edge4(input bit fs, input bit i, input bit rdy);
    fs4  = fs;
    i4   = i;
    rdy4 = rdy;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] bits4;

    // Reset state, checked while reset is held and before any clock edge.
    #1 RSTN = 1'b0;
    #2;
    model_reset();
    check8("reset");
    check("reset4.o",    32'(o4),    32'h0);
    check("reset4.vld",  32'(vld4),  32'h0);
    check("reset4.busy", 32'(busy4), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;

    // Idle with noise on I: nothing must start without FS.
    idle8("idle", 4, 1'b1);

    // Single frame 0xA5, held until one RDY cycle.
    send8("a5", 8'hA5, 1'b0, 1'b0);
    check("a5.word", 32'(o8),   32'hA5);
    check("a5.vld",  32'(vld8), 32'h1);
    idle8("a5.hold", 3, 1'b0);
    check("a5.held", 32'(vld8), 32'h1);
    edge8("a5.take", 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5.drop", 32'(vld8), 32'h0);
    check("a5.keep", 32'(o8),   32'hA5);

    // Back-to-back 0x3C then 0xC3; RDY on the second completion replaces the word.
    send8("b2b1", 8'h3C, 1'b0, 1'b0);
    check("b2b1.word", 32'(o8), 32'h3C);
    send8("b2b2", 8'hC3, 1'b1, 1'b0);
    check("b2b.word", 32'(o8),   32'hC3);
    check("b2b.vld",  32'(vld8), 32'h1);
    check("b2b.ovr",  32'(ovr8), 32'h0);
    edge8("b2b.take", 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: the second word is dropped; CLR clears OVR only.
    send8("ovr1", 8'h11, 1'b0, 1'b0);
    send8("ovr2", 8'h22, 1'b0, 1'b0);
    check("ovr.word", 32'(o8),   32'h11);
    check("ovr.flag", 32'(ovr8), 32'h1);
    edge8("ovr.clr", 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr.cleared", 32'(ovr8), 32'h0);
    check("ovr.keep",    32'(o8),   32'h11);

    // Asynchronous reset in mid-frame with VLD and OVR both set.
    send8("rst.pre", 8'h33, 1'b0, 1'b0);
    edge8("rst.f0", 1'b1, 1'b1, 1'b0, 1'b0);
    edge8("rst.f1", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.pre.vld",  32'(vld8),  32'h1);
    check("rst.pre.ovr",  32'(ovr8),  32'h1);
    check("rst.pre.busy", 32'(busy8), 32'h1);
    RSTN = 1'b0;
    #1;
    model_reset();
    check8("rst.async");
    @(negedge CLK);
    RSTN = 1'b1;

    // Abort: four ones, then FS restarts with 0x5A; only 0x5A appears.
    for (int k = 0; k < 4; k++) edge8("abort.part", k == 0, 1'b1, 1'b0, 1'b0);
    check("abort.busy", 32'(busy8), 32'h1);
    send8("abort.new", 8'h5A, 1'b0, 1'b0);
    check("abort.word", 32'(o8),   32'h5A);
    check("abort.vld",  32'(vld8), 32'h1);
    check("abort.ovr",  32'(ovr8), 32'h0);

    // CLR on the same edge as a new overrun: the set wins.
    send8("setwins", 8'h77, 1'b0, 1'b1);
    check("setwins.ovr",  32'(ovr8), 32'h1);
    check("setwins.word", 32'(o8),   32'h5A);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      edge8("rand", $urandom_range(0, 9) == 0, 1'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    fs8  = 1'b0;
    rdy8 = 1'b0;
    clr8 = 1'b0;

    // W=4, first bit lands in O[0]: serial 1,0,0,0 gives 4'h1.
    bits4 = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      edge4(k == 0, bits4[2'(k)], 1'b0);
      if (k == 2) check("lsb.early", 32'(vld4), 32'h0);
    end
    check("lsb.word", 32'(o4),   32'h1);
    check("lsb.vld",  32'(vld4), 32'h1);

    // Serial 1,1,0,1 with RDY at completion replaces the word with 4'hB.
    bits4 = 4'b1011;
    for (int k = 0; k < 4; k++) edge4(k == 0, bits4[2'(k)], k == 3);
    check("lsb2.word", 32'(o4),   32'hB);
    check("lsb2.ovr",  32'(ovr4), 32'h0);

    // Serial 0,0,1,0 with RDY low is dropped.
    bits4 = 4'b0100;
    for (int k = 0; k < 4; k++) edge4(k == 0, bits4[2'(k)], 1'b0);
    check("lsb3.word", 32'(o4),   32'hB);
    check("lsb3.ovr",  32'(ovr4), 32'h1);
    check("lsb3.busy", 32'(busy4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
